// File: rtl/game_controller.sv
// Pong match sequencer: start/serve/play/point/over FSM with scores; optional PAUSE state when PAUSE_EN is defined.
// Latency: presses and misses are registered, so state reacts one clock after sampling; outputs are registered.
// Backpressure: none; frame_tick and buttons are sampled every clock and never stalled.
module game_controller #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60,
  parameter int LEFT_LIMIT  = 4,
  parameter int RIGHT_LIMIT = 636,
  parameter int BALL_SIZE   = 9
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  input  logic        frame_tick,
  input  logic [11:0] ball_x,
  input  logic        player_1_switch,
  input  logic        player_2_switch,
  output logic        ball_run,
  output logic        ball_reset,
  output logic        serve_left,
  output logic        paddle_enable,
  output logic [3:0]  score_1,
  output logic [3:0]  score_2,
  output logic [1:0]  winner,
  output logic [2:0]  state
);

  localparam int CW = (SERVE_DELAY < 1) ? 1 : $clog2(SERVE_DELAY + 1);
  localparam logic [CW-1:0] DELAY_C = CW'(SERVE_DELAY);
  localparam logic [3:0]    WIN_C   = 4'(WIN_SCORE);
  localparam logic [12:0]   LEFT_C  = 13'(LEFT_LIMIT);
  localparam logic [12:0]   RIGHT_C = 13'(RIGHT_LIMIT);
  localparam logic [12:0]   BALL_C  = 13'(BALL_SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
`ifdef PAUSE_EN
    , S_PAUSE = 3'd5
`endif
  } state_t;

  state_t         state_q, state_d;
  logic           sw1_q, sw2_q;
  logic           press_q, press_d;
  logic           miss_l_q, miss_l_d;
  logic           miss_r_q, miss_r_d;
  logic           p2_scored_q, p2_scored_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     score_1_q, score_1_d;
  logic [3:0]     score_2_q, score_2_d;
  logic [1:0]     winner_q, winner_d;
  logic           serve_left_q, serve_left_d;
  logic           ball_run_q, ball_run_d;
  logic           ball_reset_q, ball_reset_d;
  logic           paddle_enable_q, paddle_enable_d;

  // Simultaneous presses collapse into one event.
  always_comb begin
    press_d  = (player_1_switch & ~sw1_q) | (player_2_switch & ~sw2_q);
    miss_l_d = ({1'b0, ball_x} <= LEFT_C);
    miss_r_d = (({1'b0, ball_x} + BALL_C) >= RIGHT_C);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    p2_scored_d  = p2_scored_q;
    score_1_d    = score_1_q;
    score_2_d    = score_2_q;
    winner_d     = winner_q;
    serve_left_d = serve_left_q;

    case (state_q)
      S_IDLE: begin
        if (press_q) state_d = S_SERVE;
      end
      S_SERVE: begin
        cnt_d = cnt_q;
        if (cnt_q == DELAY_C) state_d = S_PLAY;
        else if (frame_tick) cnt_d = cnt_q + CW'(1);
      end
      S_PLAY: begin
        if (miss_l_q) begin
          state_d     = S_POINT;
          p2_scored_d = 1'b1;
        end else if (miss_r_q) begin
          state_d     = S_POINT;
          p2_scored_d = 1'b0;
        end
`ifdef PAUSE_EN
        else if (press_q) state_d = S_PAUSE;
`endif
      end
      S_POINT: begin
        // serve_left points at whoever just lost the rally.
        if (p2_scored_q) begin
          score_2_d    = score_2_q + 4'd1;
          serve_left_d = 1'b1;
          if (score_2_d == WIN_C) begin
            winner_d = 2'd2;
            state_d  = S_OVER;
          end else begin
            state_d = S_SERVE;
          end
        end else begin
          score_1_d    = score_1_q + 4'd1;
          serve_left_d = 1'b0;
          if (score_1_d == WIN_C) begin
            winner_d = 2'd1;
            state_d  = S_OVER;
          end else begin
            state_d = S_SERVE;
          end
        end
      end
      S_OVER: begin
        if (press_q) begin
          score_1_d    = 4'd0;
          score_2_d    = 4'd0;
          winner_d     = 2'd0;
          serve_left_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
`ifdef PAUSE_EN
      S_PAUSE: begin
        if (press_q) state_d = S_PLAY;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    ball_reset_d    = 1'b0;
    ball_run_d      = 1'b0;
    paddle_enable_d = 1'b0;
    case (state_d)
      S_IDLE:  ball_reset_d = 1'b1;
      S_SERVE: begin
        ball_reset_d    = 1'b1;
        paddle_enable_d = 1'b1;
      end
      S_PLAY: begin
        ball_run_d      = 1'b1;
        paddle_enable_d = 1'b1;
      end
      S_POINT: paddle_enable_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q         <= S_IDLE;
      sw1_q           <= 1'b0;
      sw2_q           <= 1'b0;
      press_q         <= 1'b0;
      miss_l_q        <= 1'b0;
      miss_r_q        <= 1'b0;
      p2_scored_q     <= 1'b0;
      cnt_q           <= '0;
      score_1_q       <= 4'd0;
      score_2_q       <= 4'd0;
      winner_q        <= 2'd0;
      serve_left_q    <= 1'b0;
      ball_run_q      <= 1'b0;
      ball_reset_q    <= 1'b1;
      paddle_enable_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      sw1_q           <= player_1_switch;
      sw2_q           <= player_2_switch;
      press_q         <= press_d;
      miss_l_q        <= miss_l_d;
      miss_r_q        <= miss_r_d;
      p2_scored_q     <= p2_scored_d;
      cnt_q           <= cnt_d;
      score_1_q       <= score_1_d;
      score_2_q       <= score_2_d;
      winner_q        <= winner_d;
      serve_left_q    <= serve_left_d;
      ball_run_q      <= ball_run_d;
      ball_reset_q    <= ball_reset_d;
      paddle_enable_q <= paddle_enable_d;
    end
  end

  assign state         = state_q;
  assign ball_run      = ball_run_q;
  assign ball_reset    = ball_reset_q;
  assign paddle_enable = paddle_enable_q;
  assign serve_left    = serve_left_q;
  assign score_1       = score_1_q;
  assign score_2       = score_2_q;
  assign winner        = winner_q;

endmodule
